// File: rtl/spram_arb_pkg.sv
// Shared encodings for the SPRAM arbiter: owner tags, FSM states, strobe constants.
package spram_arb_pkg;

    // Who owns the read data that returns from the SPRAM next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_RMW  = 2'd3
    } owner_t;

    // IDLE arbitrates; RMW is the write-back half of a partial D write.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_t;

    // Port identity used for round-robin bookkeeping.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam logic [3:0] STRB_FULL = 4'hF;
    localparam logic [3:0] STRB_NONE = 4'h0;

endpackage

// File: rtl/spram_arb_merge.sv
// Byte-lane merge for read-modify-write: strobed lanes come from the new
// write data, the remaining lanes keep the word just read from the SPRAM.
module spram_arb_merge
    import spram_arb_pkg::*;
(
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] merged
);

    // Select each byte lane independently from wdata or rdata.
    always_comb begin
        merged = rdata;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                merged[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/spram_arb.sv
// Arbiter sharing one single-port 32-bit SPRAM between the instruction-fetch
// port (read-only) and the data port (read/write with byte strobes). Partial
// data writes become a read followed by a merged full-word write.
// Optional build macro: SPRAM_ARB_DPRIO_EN -- fixed priority, data port always
// wins over fetch; otherwise the two ports are served round-robin.
module spram_arb
    import spram_arb_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_wstrb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_valid
);

    state_t            state, state_next;
    owner_t            owner, owner_next;
    port_t             rr_last;
    logic [ADDR_W-1:0] rmw_addr;
    logic [DATA_W-1:0] rmw_wdata;
    logic [3:0]        rmw_wstrb;
    logic              rmw_load;
    logic              i_win, d_win;
    logic [DATA_W-1:0] merged;

    spram_arb_merge u_merge (
        .wstrb  (rmw_wstrb),
        .wdata  (rmw_wdata),
        .rdata  (mem_rd_data),
        .merged (merged)
    );

    // Pick at most one winner per cycle; only IDLE grants, nothing while in reset.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        i_win = 1'b0;
        d_win = 1'b0;
        if (rst_n && state == ST_IDLE) begin
`ifdef SPRAM_ARB_DPRIO_EN
            d_win = d_req;
            i_win = i_req && !d_req;
`else
            if (i_req && d_req) begin
                i_win = (rr_last == PORT_D);
                d_win = (rr_last == PORT_I);
            end else begin
                i_win = i_req;
                d_win = d_req;
            end
`endif
        end
    end

    assign i_gnt = i_win;
    assign d_gnt = d_win;

    // Next-state and SPRAM command decode for the granted access or the RMW write-back.
    always_comb begin
        state_next  = state;
        owner_next  = OWN_NONE;
        rmw_load    = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (rst_n) begin
            unique case (state)
                ST_IDLE: begin
                    if (i_win) begin
                        mem_rd_en  = 1'b1;
                        mem_addr   = i_addr;
                        owner_next = OWN_I;
                    end else if (d_win) begin
                        if (!d_we) begin
                            mem_rd_en  = 1'b1;
                            mem_addr   = d_addr;
                            owner_next = OWN_D;
                        end else if (d_wstrb == STRB_FULL) begin
                            mem_wr_en   = 1'b1;
                            mem_addr    = d_addr;
                            mem_wr_data = d_wdata;
                        end else if (d_wstrb != STRB_NONE) begin
                            // Partial write: fetch the old word, merge next cycle.
                            mem_rd_en  = 1'b1;
                            mem_addr   = d_addr;
                            owner_next = OWN_RMW;
                            rmw_load   = 1'b1;
                            state_next = ST_RMW;
                        end
                        // Empty strobe: grant only, no SPRAM access.
                    end
                end
                ST_RMW: begin
                    mem_wr_en   = 1'b1;
                    mem_addr    = rmw_addr;
                    mem_wr_data = merged;
                    state_next  = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Route returning read data to whichever port issued the read last cycle.
    always_comb begin
        i_valid = rst_n && mem_rd_valid && (owner == OWN_I);
        d_valid = rst_n && mem_rd_valid && (owner == OWN_D);
        i_rdata = i_valid ? mem_rd_data : '0;
        d_rdata = d_valid ? mem_rd_data : '0;
    end

    // State, ownership, round-robin pointer and latched RMW request.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner     <= OWN_NONE;
            rr_last   <= PORT_D;
            // NOTE: the RMW registers are cleared too, so a write cut short by reset leaves nothing stale behind.
            rmw_addr  <= '0;
            rmw_wdata <= '0;
            rmw_wstrb <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            if (i_win) begin
                rr_last <= PORT_I;
            end else if (d_win) begin
                rr_last <= PORT_D;
            end
            if (rmw_load) begin
                rmw_addr  <= d_addr;
                rmw_wdata <= d_wdata;
                rmw_wstrb <= d_wstrb;
            end
        end
    end

endmodule

// File: tb/tb_spram_arb.sv
// Directed, table-driven bench for spram_arb with a behavioural one-cycle-latency
// SPRAM model attached to the mem_* ports. Default build (round-robin).
module tb_spram_arb;

    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt, i_valid;
    logic [31:0]       i_rdata;
    logic              d_req, d_we;
    logic [3:0]        d_wstrb;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt, d_valid;
    logic [31:0]       d_rdata;
    logic              mem_rd_en, mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wr_data;
    logic [31:0]       mem_rd_data;
    logic              mem_rd_valid;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    spram_arb #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_gnt        (i_gnt),
        .i_valid      (i_valid),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_wstrb      (d_wstrb),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_valid      (d_valid),
        .d_rdata      (d_rdata),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid)
    );

    // Single-port SPRAM model: word addressed, read data one cycle after rd_en.
    logic [31:0] mem_model [0:8191];

    always @(posedge clk) begin
        if (mem_wr_en) mem_model[mem_addr[ADDR_W-1:2]] <= mem_wr_data;
        if (mem_rd_en) begin
            mem_rd_data  <= mem_model[mem_addr[ADDR_W-1:2]];
            mem_rd_valid <= 1'b1;
        end else begin
            mem_rd_data  <= '0;
            mem_rd_valid <= 1'b0;
        end
    end

    typedef struct {
        logic              i_req;
        logic [ADDR_W-1:0] i_addr;
        logic              d_req;
        logic              d_we;
        logic [3:0]        d_wstrb;
        logic [ADDR_W-1:0] d_addr;
        logic [31:0]       d_wdata;
        logic [1:0]        e_gnt;    // {i_gnt, d_gnt}
        logic [1:0]        e_valid;  // {i_valid, d_valid}
        logic [31:0]       e_i_rdata;
        logic [31:0]       e_d_rdata;
        logic [1:0]        e_en;     // {mem_rd_en, mem_wr_en}
        logic [ADDR_W-1:0] e_addr;
        logic [31:0]       e_wr_data;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(
        input logic ir, input logic [ADDR_W-1:0] ia,
        input logic dr, input logic dw, input logic [3:0] ds,
        input logic [ADDR_W-1:0] da, input logic [31:0] dd,
        input logic [1:0] g, input logic [1:0] v,
        input logic [31:0] ird, input logic [31:0] drd,
        input logic [1:0] en, input logic [ADDR_W-1:0] ma, input logic [31:0] mw);
        vec_t r;
        r.i_req = ir; r.i_addr = ia; r.d_req = dr; r.d_we = dw; r.d_wstrb = ds;
        r.d_addr = da; r.d_wdata = dd; r.e_gnt = g; r.e_valid = v;
        r.e_i_rdata = ird; r.e_d_rdata = drd; r.e_en = en; r.e_addr = ma; r.e_wr_data = mw;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_wstrb = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gnt"},   {30'd0, i_gnt, d_gnt}, 32'd0);
        check({tag, " valid"}, {30'd0, i_valid, d_valid}, 32'd0);
        check({tag, " rdata"}, i_rdata | d_rdata, 32'd0);
        check({tag, " en"},    {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        check({tag, " addr"},  {17'd0, mem_addr}, 32'd0);
        check({tag, " wdata"}, mem_wr_data, 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 8192; k++) mem_model[k] = 32'h0;
        mem_model[0] = 32'h11111111;  // 0x00
        mem_model[1] = 32'h22222222;  // 0x04
        mem_model[2] = 32'h33333333;  // 0x08
        mem_model[3] = 32'h44444444;  // 0x0C
        mem_model[8] = 32'h55555555;  // 0x20

        // Round-robin both ports for six cycles, then write/read/RMW/no-op sequences.
        vecs[0]  = mk(1, 'h00, 1, 0, 4'h0, 'h04, 0,            2'b10, 2'b00, 0,            0,            2'b10, 'h00, 0);
        vecs[1]  = mk(1, 'h08, 1, 0, 4'h0, 'h04, 0,            2'b01, 2'b10, 32'h11111111, 0,            2'b10, 'h04, 0);
        vecs[2]  = mk(1, 'h08, 1, 0, 4'h0, 'h0C, 0,            2'b10, 2'b01, 0,            32'h22222222, 2'b10, 'h08, 0);
        vecs[3]  = mk(1, 'h00, 1, 0, 4'h0, 'h0C, 0,            2'b01, 2'b10, 32'h33333333, 0,            2'b10, 'h0C, 0);
        vecs[4]  = mk(1, 'h00, 1, 0, 4'h0, 'h04, 0,            2'b10, 2'b01, 0,            32'h44444444, 2'b10, 'h00, 0);
        vecs[5]  = mk(1, 'h04, 1, 0, 4'h0, 'h04, 0,            2'b01, 2'b10, 32'h11111111, 0,            2'b10, 'h04, 0);
        vecs[6]  = mk(0, 'h00, 0, 0, 4'h0, 'h00, 0,            2'b00, 2'b01, 0,            32'h22222222, 2'b00, 'h00, 0);
        vecs[7]  = mk(0, 'h00, 1, 1, 4'hF, 'h10, 32'hDEADBEEF, 2'b01, 2'b00, 0,            0,            2'b01, 'h10, 32'hDEADBEEF);
        vecs[8]  = mk(0, 'h00, 1, 0, 4'h0, 'h10, 0,            2'b01, 2'b00, 0,            0,            2'b10, 'h10, 0);
        vecs[9]  = mk(0, 'h00, 0, 0, 4'h0, 'h00, 0,            2'b00, 2'b01, 0,            32'hDEADBEEF, 2'b00, 'h00, 0);
        vecs[10] = mk(0, 'h00, 1, 1, 4'h1, 'h10, 32'h000000AA, 2'b01, 2'b00, 0,            0,            2'b10, 'h10, 0);
        vecs[11] = mk(1, 'h08, 0, 0, 4'h0, 'h00, 0,            2'b00, 2'b00, 0,            0,            2'b01, 'h10, 32'hDEADBEAA);
        vecs[12] = mk(1, 'h08, 1, 0, 4'h0, 'h10, 0,            2'b10, 2'b00, 0,            0,            2'b10, 'h08, 0);
        vecs[13] = mk(0, 'h00, 1, 0, 4'h0, 'h10, 0,            2'b01, 2'b10, 32'h33333333, 0,            2'b10, 'h10, 0);
        vecs[14] = mk(0, 'h00, 0, 0, 4'h0, 'h00, 0,            2'b00, 2'b01, 0,            32'hDEADBEAA, 2'b00, 'h00, 0);
        vecs[15] = mk(0, 'h00, 1, 1, 4'h0, 'h10, 32'hFFFFFFFF, 2'b01, 2'b00, 0,            0,            2'b00, 'h00, 0);
        vecs[16] = mk(0, 'h00, 1, 0, 4'h0, 'h10, 0,            2'b01, 2'b00, 0,            0,            2'b10, 'h10, 0);
        vecs[17] = mk(0, 'h00, 0, 0, 4'h0, 'h00, 0,            2'b00, 2'b01, 0,            32'hDEADBEAA, 2'b00, 'h00, 0);

        // Reset with a request pending: everything must read zero.
        rst_n = 1'b0;
        i_req = 1'b1; i_addr = 'h04;
        d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'h3; d_addr = 'h08; d_wdata = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        drive_idle();
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post-reset idle");

        // Table vectors: drive after the edge, compare at the falling edge.
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            i_req = vecs[i].i_req; i_addr = vecs[i].i_addr;
            d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_wstrb = vecs[i].d_wstrb;
            d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
            @(negedge clk);
            check($sformatf("v%0d gnt", i),     {30'd0, i_gnt, d_gnt}, {30'd0, vecs[i].e_gnt});
            check($sformatf("v%0d valid", i),   {30'd0, i_valid, d_valid}, {30'd0, vecs[i].e_valid});
            check($sformatf("v%0d i_rdata", i), i_rdata, vecs[i].e_i_rdata);
            check($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].e_d_rdata);
            check($sformatf("v%0d mem_en", i),  {30'd0, mem_rd_en, mem_wr_en}, {30'd0, vecs[i].e_en});
            check($sformatf("v%0d mem_addr", i), {17'd0, mem_addr}, {17'd0, vecs[i].e_addr});
            check($sformatf("v%0d mem_wdata", i), mem_wr_data, vecs[i].e_wr_data);
        end

        // Reset in the cycle after a partial-write grant: the write-back must never appear.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'b0010; d_addr = 'h20; d_wdata = 32'h00007700;
        @(negedge clk);
        check("rmw-reset grant", {30'd0, d_gnt, mem_rd_en}, 32'd3);
        @(posedge clk); #1;
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("rmw-reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rmw-reset after release wr_en", {31'd0, mem_wr_en}, 32'd0);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 'h20;
        @(negedge clk);
        check("rmw-reset readback gnt", {31'd0, d_gnt}, 32'd1);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        check("rmw-reset readback valid", {31'd0, d_valid}, 32'd1);
        check("rmw-reset readback data", d_rdata, 32'h55555555);

        // Request withdrawn before being granted (during RMW): no access results.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'b1000; d_addr = 'h0C; d_wdata = 32'hAB000000;
        @(negedge clk);
        check("drop rmw grant", {31'd0, d_gnt}, 32'd1);
        @(posedge clk); #1;
        drive_idle();
        i_req = 1'b1; i_addr = 'h00;
        @(negedge clk);
        check("drop rmw wdata", mem_wr_data, 32'hAB444444);
        check("drop i_gnt in rmw", {31'd0, i_gnt}, 32'd0);
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        check("drop no access", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/spram_arb.md
Name: spram_arb

Overview:
- Arbiter/sequencer sharing one 32-bit single-port SPRAM (the `spram` block) between the core's instruction-fetch port (I, read-only) and data port (D, read/write with byte strobes).
- Grants at most one SPRAM access per cycle.
- Routes read data back to the owning port.
- Performs read-modify-write for partial D writes, because the SPRAM write mask is fixed to full word.

Parameters:
- ADDR_W, 15, byte-address width passed to the `spram` addr port.
- DATA_W, 32, word width; fixed at 32, since 4 byte strobes are assumed.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- i_gnt  out  1  request accepted this cycle.
- i_valid  out  1  i_rdata valid; exactly 1 cycle after i_gnt.
- i_rdata  out  32  fetch data.
- d_req  in  1  data request; d_* fields held stable until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_wstrb  in  4  byte-lane enables for writes.
- d_addr  in  ADDR_W  data byte address; bits [1:0] ignored.
- d_wdata  in  32  write data.
- d_gnt  out  1  request accepted this cycle.
- d_valid  out  1  read data valid, 1 cycle after d_gnt for reads.
- d_rdata  out  32  read data.
- mem_rd_en  out  1  to `spram` rd_en.
- mem_wr_en  out  1  to `spram` wr_en.
- mem_addr  out  ADDR_W  to `spram` addr.
- mem_wr_data  out  32  to `spram` wr_data.
- mem_rd_data  in  32  from `spram` rd_data.
- mem_rd_valid  in  1  from `spram` rd_valid.

Behaviour:
- Reset:
  - Clock is clk; reset rst_n is synchronous and active-low.
  - rst_n=0 at a clk edge sets state IDLE, rr_last=D, owner=NONE.
  - All outputs 0: gnt, valid, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data; rdata buses 0.
  - A pending RMW is discarded and its write is never issued. SPRAM contents are untouched.
- FSM has two states:
  - IDLE: arbitration active.
  - RMW: second cycle of a partial write.
- IDLE arbitration:
  - Requesters: i_req; d_req.
  - Only one requesting: that port wins.
  - Both requesting: round-robin, the port not granted last (rr_last) wins.
  - The winner gets a 1-cycle gnt pulse (combinational from req and state); rr_last updates to the winner.
- Grant actions by request type:
  - I or D read: mem_rd_en=1, mem_addr=addr, owner register <= port (I/D). One access per cycle, so back-to-back reads give full throughput.
  - D write with d_wstrb=4'hF: mem_wr_en=1, mem_wr_data=d_wdata. Single cycle, owner <= NONE, no d_valid.
  - D write with d_wstrb=4'h0: d_gnt pulses, no SPRAM access (no-op).
  - D partial write (strobe neither 0 nor F):
    - Grant cycle: mem_rd_en=1.
    - Latch addr, wdata and wstrb into RMW registers; owner <= RMW; next state RMW.
- RMW state:
  - Merge lane by lane: mem_wr_data lane b = wstrb[b] ? wdata lane b : mem_rd_data lane b.
  - Drive mem_wr_en=1 with the latched addr.
  - No grants this cycle; return to IDLE.
  - A partial write costs 2 SPRAM cycles.
- Return path:
  - i_valid = mem_rd_valid && owner==I; d_valid likewise for D.
  - RMW-owned returns never assert either valid.
  - i_rdata and d_rdata show mem_rd_data when their valid is set, otherwise 0.
- Ordering: D write at cycle T followed by D read of the same address at T+1 returns the new data. SPRAM ordering gives this; no forwarding is needed.
- Requests are never dropped. An ungranted req must be held; dropping req before gnt is legal and means no access.

Optional Feature:
- Macro SPRAM_ARB_DPRIO_EN.
- Defined: fixed priority; D always wins over I in IDLE, and rr_last is unused.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package holds:
  - owner encoding: OWN_NONE, OWN_I, OWN_D, OWN_RMW;
  - state encoding: ST_IDLE, ST_RMW;
  - STRB_FULL = 4'hF.
- One natural sub-module: spram_arb_merge, the combinational byte-lane merge of wdata/rdata under wstrb.
- Everything else stays in one module.

Test Plan:
- Reset mid-RMW: D partial write granted, rst_n=0 next cycle -> no mem_wr_en pulse; all outputs 0; word at that address unchanged on a later read.
- Both ports held requesting reads for 6 cycles -> grants alternate I,D,I,D,I,D (macro off) or D×6 (macro on); each valid 1 cycle after its gnt with the correct word.
- D write 32'hDEADBEEF strb F to 0x10, then D read 0x10 next cycle -> d_valid at T+2 with 32'hDEADBEEF.
- D write 32'h000000AA strb 4'b0001 to 0x10 (holding 32'hDEADBEEF) -> mem_rd_en then mem_wr_en with 32'hDEADBEAA; a read then returns 32'hDEADBEAA.
- RMW with i_req held -> i_gnt absent in the RMW cycle, granted the following cycle; no spurious i_valid/d_valid from the RMW read.
- D write strb 0 -> d_gnt pulse, no mem_rd_en/mem_wr_en, memory unchanged.
